// File: rtl/priv_intr_ctrl.sv
// Interrupt controller for the privilege block: synchronises NUM_SRC lines,
// latches pending bits, and hands one fixed-priority trap at a time to the pipeline.
module priv_intr_ctrl #(
  parameter int NUM_SRC     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CAUSE_W     = $clog2(NUM_SRC)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic [NUM_SRC-1:0] ie,
  input  logic               global_ie,
  input  logic [NUM_SRC-1:0] clear,
  input  logic               intr_ack,
  input  logic               mret,
  output logic [NUM_SRC-1:0] ip,
  output logic               intr_req,
  output logic [CAUSE_W-1:0] intr_cause,
  output logic               in_handler
);

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

  state_t state_reg;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_pipe_reg;
  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] sync_d_reg;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] ip_next;
  logic [NUM_SRC-1:0] eligible;
  logic [CAUSE_W-1:0] winner;
  logic               cause_eligible;
  logic               ack_fire;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_pipe_reg <= '0;
      sync_d_reg    <= '0;
    end else begin
      for (int s = SYNC_STAGES - 1; s > 0; s--) begin
        sync_pipe_reg[s] <= sync_pipe_reg[s-1];
      end
      sync_pipe_reg[0] <= irq_in;
      sync_d_reg       <= sync;
    end
  end

  assign sync = sync_pipe_reg[SYNC_STAGES-1];

  assign eligible       = global_ie ? (ip & ie) : '0;
  assign cause_eligible = eligible[intr_cause];
  // Only an accepted ack (still-eligible cause) may auto-clear an edge source.
  assign ack_fire       = (state_reg == REQ) && cause_eligible && intr_ack;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      assign set_vec[gi] = edge_mode[gi] ? (sync[gi] & ~sync_d_reg[gi]) : sync[gi];
      assign clr_vec[gi] = clear[gi] |
                           (ack_fire & edge_mode[gi] & (intr_cause == CAUSE_W'(gi)));
      assign ip_next[gi] = set_vec[gi] | (ip[gi] & ~clr_vec[gi]);
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ip <= '0;
    end else begin
      ip <= ip_next;
    end
  end

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = CAUSE_W'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      intr_req   <= 1'b0;
      intr_cause <= '0;
      in_handler <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|eligible) begin
            intr_cause <= winner;
            intr_req   <= 1'b1;
            state_reg  <= REQ;
          end
        end
        REQ: begin
          if (!cause_eligible) begin
            intr_req  <= 1'b0;
            state_reg <= IDLE;
          end else if (intr_ack) begin
            intr_req   <= 1'b0;
            in_handler <= 1'b1;
            state_reg  <= HANDLER;
          end
        end
        HANDLER: begin
          if (mret) begin
            in_handler <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: begin
          intr_req   <= 1'b0;
          in_handler <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/priv_intr_ctrl.md
Name: priv_intr_ctrl

Overview:
- Parametrised interrupt controller for the privilege block. Successor to the fixed three-level (u/s/m) timer/soft/ext interrupt wiring.
- Handles NUM_SRC interrupt sources. Each source is synchronised and has a per-source edge or level mode.
- Pending bits are masked by per-source enables and a global enable. The winner is chosen by fixed priority.
- One trap request at a time is handed to pipeline control through a req/ack handshake, and the handler window is tracked until mret.

Parameters:
NUM_SRC, 16, number of interrupt sources (2..64)
SYNC_STAGES, 2, synchroniser flops per source (1..3)
CAUSE_W, $clog2(NUM_SRC), width of cause index

Ports:
CLK  input  1  core clock
nRST  input  1  asynchronous active-low reset
irq_in  input  NUM_SRC  raw asynchronous interrupt lines
edge_mode  input  NUM_SRC  1 = rising-edge latched source, 0 = level source
ie  input  NUM_SRC  per-source enable (mie equivalent)
global_ie  input  1  mstatus.MIE equivalent
clear  input  NUM_SRC  software clear of pending bit (CSR write)
intr_ack  input  1  pipeline has taken the trap (pipe_clear and trap inserted)
mret  input  1  return from handler
ip  output  NUM_SRC  pending vector (mip equivalent)
intr_req  output  1  trap request to pipeline control
intr_cause  output  CAUSE_W  index of the requested source
in_handler  output  1  trap taken, mret not yet seen

Behaviour:
- Reset (async, nRST=0): all synchroniser flops, ip, intr_req, intr_cause, in_handler are 0; FSM in IDLE. Reset mid-handshake abandons the request with no residue.
- Synchroniser: SYNC_STAGES flops per bit. sync[i] is the last stage; sync_d[i] is sync[i] delayed one cycle, used for edge detection.
- Pending update, per bit i, each cycle:
  - Edge mode: set = sync & ~sync_d.
  - Level mode: set = sync.
  - Clear sources: clear[i], or auto-clear at intr_ack for the acked source in edge mode only.
  - Set wins over clear in the same cycle.
  - Level-mode bits re-set next cycle while the line stays high.
- Priority: eligible = ip & ie, gated by global_ie. Lowest index has highest priority.
- FSM states:
  - IDLE: intr_req=0. If any bit is eligible, latch the winner into intr_cause and go to REQ.
  - REQ: intr_req=1, intr_cause held stable.
    - If the latched bit is no longer eligible (cleared, disabled, or global_ie dropped), go to IDLE and deassert intr_req. No ack is expected.
    - Else if intr_ack=1, go to HANDLER.
    - Ack takes precedence over withdrawal only if both occur in the same cycle while the bit is still eligible.
    - A higher-priority source arriving in REQ does not replace the latched cause.
  - HANDLER: intr_req=0, in_handler=1. Eligibility is ignored (no nesting). On mret=1, go to IDLE, where a new winner may be latched from the next cycle.
- intr_ack outside REQ is ignored. mret outside HANDLER is ignored.
- Latency: irq_in rising and stable before edge 1 sets ip on edge SYNC_STAGES+1. intr_req is asserted after edge SYNC_STAGES+2, which is 4 edges for the default configuration.
- ip reflects the registered pending vector. Clear/set effects appear the cycle after.

Test Plan:
- Reset values: drive irq_in=0xFFFF, ie=0xFFFF, global_ie=1, hold nRST=0 → ip=0, intr_req=0, in_handler=0. Release nRST → intr_req=1 with intr_cause=0 exactly 4 edges later.
- Edge source, full handshake: edge_mode[5]=1, ie[5]=1, pulse irq_in[5] for 1 cycle.
  - ip[5]=1, then intr_req=1 with cause=5.
  - intr_ack → ip[5]=0, in_handler=1.
  - mret → IDLE, no further request.
- Priority and no-preemption:
  - Raise sources 9 and 3 together (level, enabled) → cause=3.
  - Raise source 1 while in REQ → cause stays 3.
  - After ack and mret, with source 1 still high → next cause=1.
- Withdrawal: in REQ with cause=7, drop ie[7] → intr_req=0 next cycle, FSM IDLE. A later intr_ack pulse has no effect and in_handler stays 0.
- Set/clear collision: in edge mode, assert clear[2] in the same cycle as the synced rising edge of source 2 → ip[2]=1. In level mode with the line held high, pulse clear[4] → ip[4] reads 1 again within one cycle.
- Masking and nesting: with global_ie=0 and ip=0x0010, intr_req stays 0. Set global_ie=1 → request. While in HANDLER, a new eligible source produces no intr_req until mret.
